// File: rtl/countdown_timer_mc_if.sv
// Panel/display bundle for the multi-channel countdown timer: tick, mode switch,
// channel select and keys in; selected-channel value and per-channel status out.
interface countdown_timer_mc_if #(
  parameter int NUM_CH = 4,
  parameter int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              tick;
  logic              sw_timer;
  logic [CW-1:0]     ch_sel;
  logic              key_next;
  logic              key_inc;
  logic              key_dec;
  logic              key_start;
  logic [5:0]        sel_seconds;
  logic [5:0]        sel_minutes;
  logic [4:0]        sel_hours;
  logic [4:0]        sel_days;
  logic [1:0]        set_index;
  logic [NUM_CH-1:0] running;
  logic [NUM_CH-1:0] expired;
  logic              alarm;

  modport master (
    output tick, sw_timer, ch_sel, key_next, key_inc, key_dec, key_start,
    input  sel_seconds, sel_minutes, sel_hours, sel_days, set_index,
           running, expired, alarm
  );

  modport slave (
    input  tick, sw_timer, ch_sel, key_next, key_inc, key_dec, key_start,
    output sel_seconds, sel_minutes, sel_hours, sel_days, set_index,
           running, expired, alarm
  );
endinterface

// File: rtl/countdown_timer_mc.sv
// NUM_CH independent day:hour:minute:second countdowns edited from a shared key
// panel, counted down on a 1 Hz tick, with per-channel alarm counters merged into one alarm.
module countdown_timer_mc #(
  parameter int NUM_CH     = 4,
  parameter int DAY_MAX    = 31,
  parameter int ALARM_SECS = 10
) (
  input logic                 clk,
  input logic                 rst_n,
  countdown_timer_mc_if.slave bus
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS + 1) : 1;

  typedef enum logic [1:0] {
    ST_SET     = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] vmax,
                                           input logic up, input logic dn);
    logic [5:0] r;
    if (up && !dn) begin
      r = (v == vmax) ? 6'd0 : v + 6'd1;
    end else if (dn && !up) begin
      r = (v == 6'd0) ? vmax : v - 6'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t      state_r [NUM_CH];
  state_t      state_s [NUM_CH];
  logic [5:0]  sec_r   [NUM_CH];
  logic [5:0]  sec_s   [NUM_CH];
  logic [5:0]  min_r   [NUM_CH];
  logic [5:0]  min_s   [NUM_CH];
  logic [4:0]  hr_r    [NUM_CH];
  logic [4:0]  hr_s    [NUM_CH];
  logic [4:0]  day_r   [NUM_CH];
  logic [4:0]  day_s   [NUM_CH];
  logic [AW-1:0] alarm_cnt_r [NUM_CH];
  logic [AW-1:0] alarm_cnt_s [NUM_CH];

  logic [1:0]        set_index_r;
  logic [1:0]        set_index_s;
  logic [CW-1:0]     ch_sel_r;
  logic              next_prev_r;
  logic              inc_prev_r;
  logic              dec_prev_r;
  logic              start_prev_r;
  logic              next_p_s;
  logic              inc_p_s;
  logic              dec_p_s;
  logic              start_p_s;
  logic [NUM_CH-1:0] hit_s;
  logic [NUM_CH-1:0] nonzero_s;

  assign next_p_s  = bus.key_next  & ~next_prev_r;
  assign inc_p_s   = bus.key_inc   & ~inc_prev_r;
  assign dec_p_s   = bus.key_dec   & ~dec_prev_r;
  assign start_p_s = bus.key_start & ~start_prev_r;

  // Key history starts high so a key held through reset never counts as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_prev_r  <= 1'b1;
      inc_prev_r   <= 1'b1;
      dec_prev_r   <= 1'b1;
      start_prev_r <= 1'b1;
      ch_sel_r     <= '0;
      set_index_r  <= 2'd0;
    end else begin
      next_prev_r  <= bus.key_next;
      inc_prev_r   <= bus.key_inc;
      dec_prev_r   <= bus.key_dec;
      start_prev_r <= bus.key_start;
      ch_sel_r     <= bus.ch_sel;
      set_index_r  <= set_index_s;
    end
  end

  // Edited field: cleared by mode-off or a channel switch, otherwise stepped by key_next.
  always_comb begin
    set_index_s = set_index_r;
    if (!bus.sw_timer || (bus.ch_sel != ch_sel_r)) begin
      set_index_s = 2'd0;
    end else if (next_p_s) begin
      set_index_s = set_index_r + 2'd1;
    end else begin
      set_index_s = set_index_r;
    end
  end

  // Channel select decode and nonzero detect.
  always_comb begin
    hit_s     = '0;
    nonzero_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit_s[i]     = (bus.ch_sel == CW'(i));
      nonzero_s[i] = |{sec_r[i], min_r[i], hr_r[i], day_r[i]};
    end
  end

  // Per-channel next state: edits, start/pause, borrow-chain countdown and alarm counter.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_s[i]     = state_r[i];
      sec_s[i]       = sec_r[i];
      min_s[i]       = min_r[i];
      hr_s[i]        = hr_r[i];
      day_s[i]       = day_r[i];
      alarm_cnt_s[i] = alarm_cnt_r[i];

      if (!bus.sw_timer) begin
        state_s[i]     = ST_SET;
        sec_s[i]       = 6'd0;
        min_s[i]       = 6'd0;
        hr_s[i]        = 5'd0;
        day_s[i]       = 5'd0;
        alarm_cnt_s[i] = '0;
      end else begin
        if (bus.tick && (alarm_cnt_r[i] != '0)) begin
          alarm_cnt_s[i] = alarm_cnt_r[i] - AW'(1);
        end else begin
          alarm_cnt_s[i] = alarm_cnt_r[i];
        end

        case (state_r[i])
          ST_SET, ST_PAUSE: begin
            if (hit_s[i]) begin
              case (set_index_r)
                2'd0:    sec_s[i] = wrap_step(sec_r[i], 6'd59, inc_p_s, dec_p_s);
                2'd1:    min_s[i] = wrap_step(min_r[i], 6'd59, inc_p_s, dec_p_s);
                2'd2:    hr_s[i]  = 5'(wrap_step({1'b0, hr_r[i]}, 6'd23, inc_p_s, dec_p_s));
                2'd3:    day_s[i] = 5'(wrap_step({1'b0, day_r[i]}, 6'(DAY_MAX), inc_p_s, dec_p_s));
                default: sec_s[i] = sec_r[i];
              endcase
              if (start_p_s && nonzero_s[i]) begin
                state_s[i] = ST_RUN;
              end else if (start_p_s) begin
                state_s[i] = ST_SET;
              end else begin
                state_s[i] = state_r[i];
              end
            end else begin
              state_s[i] = state_r[i];
            end
          end
          ST_RUN: begin
            // A start press in the same cycle as tick pauses before the tick is counted.
            if (hit_s[i] && start_p_s) begin
              state_s[i] = ST_PAUSE;
            end else if (bus.tick) begin
              if (sec_r[i] != 6'd0) begin
                sec_s[i] = sec_r[i] - 6'd1;
              end else if (min_r[i] != 6'd0) begin
                sec_s[i] = 6'd59;
                min_s[i] = min_r[i] - 6'd1;
              end else if (hr_r[i] != 5'd0) begin
                sec_s[i] = 6'd59;
                min_s[i] = 6'd59;
                hr_s[i]  = hr_r[i] - 5'd1;
              end else begin
                sec_s[i] = 6'd59;
                min_s[i] = 6'd59;
                hr_s[i]  = 5'd23;
                day_s[i] = day_r[i] - 5'd1;
              end
              if ((sec_r[i] == 6'd1) && (min_r[i] == 6'd0) && (hr_r[i] == 5'd0) && (day_r[i] == 5'd0)) begin
                state_s[i]     = ST_EXPIRED;
                alarm_cnt_s[i] = AW'(ALARM_SECS);
              end else begin
                state_s[i] = ST_RUN;
              end
            end else begin
              state_s[i] = ST_RUN;
            end
          end
          ST_EXPIRED: begin
            if (hit_s[i] && start_p_s) begin
              state_s[i]     = ST_SET;
              alarm_cnt_s[i] = '0;
            end else begin
              state_s[i] = ST_EXPIRED;
            end
          end
          default: state_s[i] = ST_SET;
        endcase
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i]     <= ST_SET;
        sec_r[i]       <= 6'd0;
        min_r[i]       <= 6'd0;
        hr_r[i]        <= 5'd0;
        day_r[i]       <= 5'd0;
        alarm_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i]     <= state_s[i];
        sec_r[i]       <= sec_s[i];
        min_r[i]       <= min_s[i];
        hr_r[i]        <= hr_s[i];
        day_r[i]       <= day_s[i];
        alarm_cnt_r[i] <= alarm_cnt_s[i];
      end
    end
  end

  // Selected-channel mux and status decode of registered state.
  always_comb begin
    bus.sel_seconds = 6'd0;
    bus.sel_minutes = 6'd0;
    bus.sel_hours   = 5'd0;
    bus.sel_days    = 5'd0;
    bus.running     = '0;
    bus.expired     = '0;
    bus.alarm       = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hit_s[i]) begin
        bus.sel_seconds = sec_r[i];
        bus.sel_minutes = min_r[i];
        bus.sel_hours   = hr_r[i];
        bus.sel_days    = day_r[i];
      end else begin
        bus.alarm = bus.alarm;
      end
      bus.running[i] = (state_r[i] == ST_RUN);
      bus.expired[i] = (state_r[i] == ST_EXPIRED);
      bus.alarm      = bus.alarm | (alarm_cnt_r[i] != '0);
    end
  end

  assign bus.set_index = set_index_r;

endmodule

// File: tb/tb_countdown_timer_mc.sv
// Directed bench for countdown_timer_mc with 4 channels, DAY_MAX 31, ALARM_SECS 10.
module tb_countdown_timer_mc;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  countdown_timer_mc_if #(.NUM_CH(4)) bus ();

  countdown_timer_mc #(.NUM_CH(4), .DAY_MAX(31), .ALARM_SECS(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: bus.key_next  = v;
      1: bus.key_inc   = v;
      2: bus.key_dec   = v;
      default: bus.key_start = v;
    endcase
  endtask

  // k: 0 next, 1 inc, 2 dec, 3 start
  task automatic press(input int k, input int n);
    repeat (n) begin
      set_key(k, 1'b1);
      cyc(1);
      set_key(k, 1'b0);
      cyc(1);
    end
  endtask

  task automatic do_tick(input int n);
    repeat (n) begin
      bus.tick = 1'b1;
      cyc(1);
      bus.tick = 1'b0;
      cyc(1);
    end
  endtask

  task automatic select(input logic [1:0] ch);
    bus.ch_sel = ch;
    cyc(1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.tick = 1'b0;
    bus.sw_timer = 1'b1;
    bus.ch_sel = 2'd0;
    bus.key_next = 1'b0;
    bus.key_inc = 1'b0;
    bus.key_dec = 1'b0;
    bus.key_start = 1'b0;
    cyc(3);
    check_val("rst_running", bus.running, 0);
    check_val("rst_expired", bus.expired, 0);
    check_val("rst_alarm", bus.alarm, 0);
    check_val("rst_sec", bus.sel_seconds, 0);
    check_val("rst_index", bus.set_index, 0);
    rst_n = 1'b1;
    cyc(2);

    // ch0: 0 -> 59 -> 58, then up five to 3, run to expiry
    press(2, 2);
    check_val("dec_wrap_sec", bus.sel_seconds, 58);
    press(1, 5);
    check_val("inc_wrap_sec", bus.sel_seconds, 3);
    press(3, 1);
    check_val("start_ch0", bus.running, 4'b0001);
    do_tick(2);
    check_val("count_sec", bus.sel_seconds, 1);
    do_tick(1);
    check_val("expire_flag", bus.expired, 4'b0001);
    check_val("expire_run", bus.running, 0);
    check_val("alarm_on", bus.alarm, 1);
    do_tick(9);
    check_val("alarm_9ticks", bus.alarm, 1);
    do_tick(1);
    check_val("alarm_off", bus.alarm, 0);
    press(3, 1);
    check_val("exp_to_set", bus.expired, 0);

    // ch1: 1 day, borrow through every field
    select(2'd1);
    press(0, 3);
    check_val("index_day", bus.set_index, 3);
    press(1, 1);
    check_val("day_set", bus.sel_days, 1);
    press(3, 1);
    do_tick(1);
    check_val("borrow_day", bus.sel_days, 0);
    check_val("borrow_hr", bus.sel_hours, 23);
    check_val("borrow_min", bus.sel_minutes, 59);
    check_val("borrow_sec", bus.sel_seconds, 59);
    check_val("borrow_run", bus.running, 4'b0010);
    press(3, 1);
    check_val("ch1_pause", bus.running, 0);

    // ch0 = 5 s and ch2 = 2 s running together
    select(2'd0);
    check_val("chsel_index_clr", bus.set_index, 0);
    press(1, 5);
    press(3, 1);
    select(2'd2);
    press(1, 2);
    press(3, 1);
    check_val("two_run", bus.running, 4'b0101);
    do_tick(2);
    check_val("two_expired", bus.expired, 4'b0100);
    check_val("two_alarm", bus.alarm, 1);
    bus.ch_sel = 2'd0;
    #1;
    check_val("mux_ch0_sec", bus.sel_seconds, 3);
    select(2'd2);
    press(3, 1);
    check_val("ch2_clear_alarm", bus.alarm, 0);

    // ch0: pause at 3, edit to 10, then start and tick together
    select(2'd0);
    press(3, 1);
    press(1, 7);
    check_val("pause_edit", bus.sel_seconds, 10);
    press(3, 1);
    bus.key_start = 1'b1;
    bus.tick = 1'b1;
    cyc(1);
    bus.key_start = 1'b0;
    bus.tick = 1'b0;
    cyc(1);
    check_val("start_beats_tick", bus.running, 0);
    check_val("start_tick_sec", bus.sel_seconds, 10);
    bus.key_inc = 1'b1;
    cyc(3);
    bus.key_inc = 1'b0;
    cyc(1);
    check_val("held_inc_once", bus.sel_seconds, 11);
    press(3, 1);
    check_val("resume", bus.running, 4'b0001);

    // ch3: zero start, inc+dec together, day and hour wraps
    select(2'd3);
    press(3, 1);
    check_val("zero_start", bus.running, 4'b0001);
    bus.key_inc = 1'b1;
    bus.key_dec = 1'b1;
    cyc(1);
    bus.key_inc = 1'b0;
    bus.key_dec = 1'b0;
    cyc(1);
    check_val("inc_dec_same", bus.sel_seconds, 0);
    press(0, 3);
    press(2, 1);
    check_val("day_wrap", bus.sel_days, 31);
    press(0, 3);
    check_val("index_hr", bus.set_index, 2);
    press(2, 1);
    check_val("hr_dec_wrap", bus.sel_hours, 23);
    press(1, 1);
    check_val("hr_inc_wrap", bus.sel_hours, 0);

    // mode switch off clears everything; re-entry with keys held is not a press
    bus.sw_timer = 1'b0;
    cyc(1);
    check_val("sw_running", bus.running, 0);
    check_val("sw_index", bus.set_index, 0);
    check_val("sw_days", bus.sel_days, 0);
    bus.key_start = 1'b1;
    bus.key_next = 1'b1;
    cyc(1);
    bus.sw_timer = 1'b1;
    cyc(2);
    check_val("reentry_index", bus.set_index, 0);
    check_val("reentry_run", bus.running, 0);
    bus.key_start = 1'b0;
    bus.key_next = 1'b0;
    cyc(1);

    // async reset mid-count
    select(2'd0);
    press(1, 2);
    press(3, 1);
    press(0, 1);
    check_val("pre_rst_run", bus.running, 4'b0001);
    check_val("pre_rst_index", bus.set_index, 1);
    rst_n = 1'b0;
    #1;
    check_val("async_running", bus.running, 0);
    check_val("async_sec", bus.sel_seconds, 0);
    check_val("async_index", bus.set_index, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
